// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, FSM state type and index-counter width helper for the dense-layer engines.
// Contents: DATA_W (operand width), ACC_W (accumulator width), state_t {IDLE, RUN, DONE}, cnt_w().
package nn_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Width of a counter walking v positions of the M x N loop; kept at least 1 so a
    // single-entry dimension still gets a real register bit.
    function automatic int cnt_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bwd_mac.sv
// bwd_mac: combinational multiply-accumulate step for the backward pass.
// Ports: w, g (8-bit weight and gradient), acc (16-bit running sum) -> next_acc (16-bit).
// Build option DX_SAT_EN: when defined, sums above 16'hFFFF clamp; otherwise they wrap modulo 2^16.
module bwd_mac
    import nn_pkg::*;
(
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] g,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  next_acc
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum = {1'b0, acc} + (ACC_W+1)'(w) * (ACC_W+1)'(g);
`ifdef DX_SAT_EN
        next_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dense_backward_seq.sv
// dense_backward_seq: sequential dense-layer input gradient dx = W^T * dy, one MAC per clock.
// Ports: clk, rst (sync, active high); in_valid/in_ready with W [0:M-1][0:N-1] x 8b and dy [0:M-1] x 8b;
//        out_valid/out_ready with dx [0:N-1] x 16b.
// Build option DX_SAT_EN (in bwd_mac): saturating instead of wrapping accumulation.
module dense_backward_seq
    import nn_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [0:M-1][0:N-1][DATA_W-1:0]      W,
    input  logic [0:M-1][DATA_W-1:0]             dy,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [0:N-1][ACC_W-1:0]              dx
);

    localparam int IW = cnt_w(M);
    localparam int JW = cnt_w(N);

    state_t                          state_q, state_d;
    logic [0:M-1][0:N-1][DATA_W-1:0] w_q;
    logic [0:M-1][DATA_W-1:0]        dy_q;
    logic [0:N-1][ACC_W-1:0]         dx_q;
    logic [ACC_W-1:0]                acc_q, next_acc;
    logic [IW-1:0]                   i_q;
    logic [JW-1:0]                   j_q;
    logic                            last_i, last_j;

    assign last_i    = i_q == IW'(M - 1);
    assign last_j    = j_q == JW'(N - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign dx        = dx_q;

    bwd_mac u_mac (
        .w        (w_q[i_q][j_q]),
        .g        (dy_q[i_q]),
        .acc      (acc_q),
        .next_acc (next_acc)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && in_valid)          state_d = RUN;
        if (state_q == RUN && last_i && last_j)   state_d = DONE;
        if (state_q == DONE && out_ready)         state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            dx_q    <= '0;
        end else begin
            state_q <= state_d;
            if (in_ready && in_valid) begin
                w_q   <= W;
                dy_q  <= dy;
                acc_q <= '0;
                i_q   <= '0;
                j_q   <= '0;
            end else if (state_q == RUN) begin
                // Column j finishes on its last row: commit the column sum and restart the accumulator.
                if (last_i) begin
                    dx_q[j_q] <= next_acc;
                    acc_q     <= '0;
                    i_q       <= '0;
                    j_q       <= last_j ? '0 : j_q + 1'b1;
                end else begin
                    acc_q <= next_acc;
                    i_q   <= i_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dense_backward_seq.sv
// tb_dense_backward_seq: self-checking bench for dense_backward_seq (2x2 instance and a 1-column instance).
module tb_dense_backward_seq;

    typedef logic [0:1][0:1][7:0] wa_t;
    typedef logic [0:1][7:0]      dya_t;
    typedef logic [0:1][15:0]     dxa_t;
    typedef logic [0:1][0:0][7:0] wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
    wa_t  W  = '0;
    dya_t dy = '0;
    dxa_t dx;

    logic b_in_valid = 1'b0, b_out_ready = 1'b0, b_in_ready, b_out_valid;
    wb_t  b_W  = '0;
    dya_t b_dy = '0;
    logic [0:0][15:0] b_dx;

    dense_backward_seq #(.N(2), .M(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .W(W), .dy(dy),
        .out_valid(out_valid), .out_ready(out_ready), .dx(dx)
    );

    dense_backward_seq #(.N(1), .M(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .W(b_W), .dy(b_dy),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dx(b_dx)
    );

    int n_chk  = 0;
    int n_fail = 0;

    localparam wa_t  BASIC_W  = {8'd1, 8'd2, 8'd3, 8'd4};
    localparam dya_t BASIC_DY = {8'd5, 8'd6};
    localparam dxa_t BASIC_DX = {16'd23, 16'd34};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accumulate following the arithmetic rule: plain integer sum, then clamp or wrap.
    function automatic int mac(input int acc, input int w, input int g);
        int s;
        s = acc + w * g;
`ifdef DX_SAT_EN
        return (s > 65535) ? 65535 : s;
`else
        return s % 65536;
`endif
    endfunction

    function automatic dxa_t model_a(input wa_t w, input dya_t g);
        dxa_t r;
        for (int j = 0; j < 2; j++) begin
            int acc = 0;
            for (int i = 0; i < 2; i++) acc = mac(acc, int'(w[i][j]), int'(g[i]));
            r[j] = 16'(acc);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_b(input wb_t w, input dya_t g);
        int acc = 0;
        for (int i = 0; i < 2; i++) acc = mac(acc, int'(w[i][0]), int'(g[i]));
        return 16'(acc);
    endfunction

    // Offers one job to the 2x2 instance (must be idle) and returns cycles until out_valid, or -1.
    task automatic run_a(input wa_t w, input dya_t g, output int lat);
        W = w; dy = g; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic run_b(input wb_t w, input dya_t g, output int lat);
        b_W = w; b_dy = g; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!b_out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (dx !== '0) begin n_fail++; $display("FAIL reset_dx got=%h exp=0", dx); end
        n_chk++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b got rdy=%b vld=%b exp 1/0", b_in_ready, b_out_valid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        run_a(BASIC_W, BASIC_DY, lat);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        n_chk++; if (dx !== BASIC_DX) begin n_fail++; $display("FAIL basic_dx got=%h exp=%h", dx, BASIC_DX); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_in_done got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handshake got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_width();
        int lat;
        logic [15:0] exp_dx;
`ifdef DX_SAT_EN
        exp_dx = 16'd65535;
`else
        exp_dx = 16'd64514;
`endif
        run_b('1, '1, lat);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL width_latency got=%0d exp=2", lat); end
        n_chk++; if (b_dx[0] !== exp_dx) begin n_fail++; $display("FAIL width_dx got=%0d exp=%0d", b_dx[0], exp_dx); end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        wa_t  w = wa_t'({$urandom, $urandom});
        dya_t g = dya_t'($urandom);
        dxa_t e = model_a(w, g);
        run_a(w, g, lat);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        in_valid = 1'b1;
        W = ~w; dy = ~g;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, out_valid); end
            n_chk++; if (dx !== e) begin n_fail++; $display("FAIL bp_dx cyc=%0d got=%h exp=%h", k, dx, e); end
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_capture();
        int lat = 0;
        W = BASIC_W; dy = BASIC_DY; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        W = '0; dy = {8'd9, 8'd9};
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL capture_latency got=%0d exp=4", lat); end
        n_chk++; if (dx !== BASIC_DX) begin n_fail++; $display("FAIL capture_dx got=%h exp=%h", dx, BASIC_DX); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        W = BASIC_W; dy = BASIC_DY; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        n_chk++; if (dx !== '0) begin n_fail++; $display("FAIL midrst_dx got=%h exp=0", dx); end
        run_a(BASIC_W, BASIC_DY, lat);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d exp=4", lat); end
        n_chk++; if (dx !== BASIC_DX) begin n_fail++; $display("FAIL midrst_fresh_dx got=%h exp=%h", dx, BASIC_DX); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   t = 0, t1 = -1, t2 = -1, rdy_after = -1;
        dxa_t d1 = '0, d2 = '0;
        wa_t  w2 = wa_t'({$urandom, $urandom});
        dya_t g2 = dya_t'($urandom);
        W = BASIC_W; dy = BASIC_DY; in_valid = 1'b1; out_ready = 1'b1;
        step();
        W = w2; dy = g2;
        while (t2 < 0 && t < 40) begin
            step();
            t++;
            if (t == t1 + 1 && t1 >= 0) rdy_after = int'(in_ready);
            if (out_valid && t1 < 0) begin t1 = t; d1 = dx; end
            else if (out_valid && t1 >= 0 && t > t1 + 1) begin t2 = t; d2 = dx; end
        end
        in_valid = 1'b0;
        n_chk++; if (t1 !== 4) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=4", t1); end
        n_chk++; if (d1 !== BASIC_DX) begin n_fail++; $display("FAIL b2b_first_dx got=%h exp=%h", d1, BASIC_DX); end
        n_chk++; if (rdy_after !== 1) begin n_fail++; $display("FAIL b2b_ready_after_handshake got=%0d exp=1", rdy_after); end
        n_chk++; if (t2 - t1 !== 6) begin n_fail++; $display("FAIL b2b_period got=%0d exp=6", t2 - t1); end
        n_chk++; if (d2 !== model_a(w2, g2)) begin n_fail++; $display("FAIL b2b_second_dx got=%h exp=%h", d2, model_a(w2, g2)); end
        step();
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 12; k++) begin
            wa_t  w = wa_t'({$urandom, $urandom});
            dya_t g = dya_t'($urandom);
            if (k < 2) begin w = '1; g = '1; end
            run_a(w, g, lat);
            n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL rand_latency job=%0d got=%0d exp=4", k, lat); end
            n_chk++; if (dx !== model_a(w, g)) begin n_fail++; $display("FAIL rand_dx job=%0d got=%h exp=%h", k, dx, model_a(w, g)); end
            repeat ($urandom_range(0, 2)) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            wb_t  w = wb_t'($urandom);
            dya_t g = dya_t'($urandom);
            run_b(w, g, lat);
            n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL rand_b_latency job=%0d got=%0d exp=2", k, lat); end
            n_chk++; if (b_dx[0] !== model_b(w, g)) begin n_fail++; $display("FAIL rand_b_dx job=%0d got=%0d exp=%0d", k, b_dx[0], model_b(w, g)); end
            b_out_ready = 1'b1;
            step();
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_width();
        test_backpressure();
        test_capture();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
